// File: rtl/adder_operand_recover_if.sv
// Handshake bundle for adder_operand_recover: sum/a in, saturated b/b_ovf out, plus error count.
interface adder_operand_recover_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] b;
  logic             b_ovf;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, sum, a, out_ready,
    input  in_ready, out_valid, b, b_ovf, err_count
  );

  modport slave (
    input  in_valid, sum, a, out_ready,
    output in_ready, out_valid, b, b_ovf, err_count
  );
endinterface

// File: rtl/adder_operand_recover.sv
// Recovers b = sum - a with saturation and overflow count; 2-cycle latency, 1/cycle.
// Backpressure: out_ready stalls stage 2, then stage 1; in_ready is combinational from out_ready.
module adder_operand_recover #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  adder_operand_recover_if.slave bus
);
  localparam logic signed [WIDTH+1:0] MAX_D = (WIDTH+2)'((2 ** (WIDTH-1)) - 1);
  // Two's complement: ~MAX equals the most negative operand value.
  localparam logic signed [WIDTH+1:0] MIN_D = ~MAX_D;
  localparam logic [WIDTH-1:0] B_MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] B_MAXN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                    s1_valid_q;
  logic signed [WIDTH+1:0] diff_q, diff_d;
  logic                    out_valid_q;
  logic [WIDTH-1:0]        b_q, b_d;
  logic                    b_ovf_q, b_ovf_d;
  logic [CNT_W-1:0]        err_q;

  logic s2_adv, s1_adv, in_xfer, out_xfer;

  always_comb begin
    s2_adv   = !out_valid_q || bus.out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_xfer  = bus.in_valid && !rst && s1_adv;
    out_xfer = out_valid_q && bus.out_ready;
    diff_d   = $signed({bus.sum[WIDTH], bus.sum}) - $signed({{2{bus.a[WIDTH-1]}}, bus.a});
  end

  always_comb begin
    b_d     = diff_q[WIDTH-1:0];
    b_ovf_d = 1'b0;
    if (diff_q > MAX_D) begin
      b_d     = B_MAXP;
      b_ovf_d = 1'b1;
    end else if (diff_q < MIN_D) begin
      b_d     = B_MAXN;
      b_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      diff_q     <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_xfer;
      if (in_xfer) diff_q <= diff_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      b_q         <= '0;
      b_ovf_q     <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        b_q     <= b_d;
        b_ovf_q <= b_ovf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (out_xfer && b_ovf_q && (err_q != CNT_MAX)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign bus.in_ready  = !rst && s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.b         = b_q;
  assign bus.b_ovf     = b_ovf_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_adder_operand_recover.sv
// Directed bench for adder_operand_recover: vector table plus backpressure/reset/counter sequences.
module tb_adder_operand_recover;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  adder_operand_recover_if #(.WIDTH(4), .CNT_W(8)) bus ();

  adder_operand_recover #(.WIDTH(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0] sum;
    logic [3:0] a;
    logic [3:0] b;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{5'h1F, 4'h7, 4'h8, 1'b0};  // -1 - 7 = -8
    vecs[1] = '{5'h0E, 4'h7, 4'h7, 1'b0};  // 14 - 7 = 7
    vecs[2] = '{5'h10, 4'h8, 4'h8, 1'b0};  // -16 - -8 = -8
    vecs[3] = '{5'h00, 4'h0, 4'h0, 1'b0};
    vecs[4] = '{5'h0F, 4'h8, 4'h7, 1'b1};  // 23 saturates high
    vecs[5] = '{5'h10, 4'h7, 4'h8, 1'b1};  // -23 saturates low

    bus.in_valid  = 1'b1;
    bus.sum       = 5'h05;
    bus.a         = 4'h1;
    bus.out_ready = 1'b1;

    // Reset held two cycles with input offered
    rst = 1'b1;
    step();
    step();
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_b", 32'(bus.b), 0);
    check("rst_b_ovf", 32'(bus.b_ovf), 0);
    check("rst_err", 32'(bus.err_count), 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Table: one transfer, then result exactly two edges later
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.sum = vecs[i].sum;
      bus.a   = vecs[i].a;
      check($sformatf("v%0d_accept", i), 32'(bus.in_ready), 1);
      step();
      bus.in_valid = 1'b0;
      check($sformatf("v%0d_lat1_valid", i), 32'(bus.out_valid), 0);
      step();
      check($sformatf("v%0d_valid", i), 32'(bus.out_valid), 1);
      check($sformatf("v%0d_b", i), 32'(bus.b), 32'(vecs[i].b));
      check($sformatf("v%0d_ovf", i), 32'(bus.b_ovf), 32'(vecs[i].ovf));
    end
    step();
    check("err_after_sat", 32'(bus.err_count), 2);
    check("drained", 32'(bus.out_valid), 0);

    // Backpressure: three offers, two fit
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a = 4'h0;
    bus.sum = 5'd1;
    check("bp_acc0", 32'(bus.in_ready), 1);
    step();
    bus.sum = 5'd2;
    check("bp_acc1", 32'(bus.in_ready), 1);
    step();
    bus.sum = 5'd3;
    check("bp_full", 32'(bus.in_ready), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp_hold_rdy%0d", k), 32'(bus.in_ready), 0);
      check($sformatf("bp_hold_b%0d", k), 32'(bus.b), 1);
      check($sformatf("bp_hold_vld%0d", k), 32'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    check("bp_out1_vld", 32'(bus.out_valid), 1);
    check("bp_out1_b", 32'(bus.b), 2);
    step();
    check("bp_out2_vld", 32'(bus.out_valid), 1);
    check("bp_out2_b", 32'(bus.b), 3);
    step();
    check("bp_empty", 32'(bus.out_valid), 0);

    // Reset with two overflowing results in flight
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sum = 5'h0F;
    bus.a   = 4'h8;
    step();
    step();
    bus.in_valid = 1'b0;
    check("mid_inflight", 32'(bus.out_valid), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_vld", 32'(bus.out_valid), 0);
    check("mid_rst_err", 32'(bus.err_count), 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("mid_no_stale%0d", k), 32'(bus.out_valid), 0);
    end
    check("mid_err_stays0", 32'(bus.err_count), 0);

    // Counter saturation: 260 back-to-back overflowing results
    bus.in_valid = 1'b1;
    bus.sum = 5'h10;
    bus.a   = 4'h7;
    for (int k = 0; k < 260; k++) begin
      if (bus.in_ready !== 1'b1) check($sformatf("cnt_accept%0d", k), 32'(bus.in_ready), 1);
      step();
    end
    bus.in_valid = 1'b0;
    check("cnt_stream_b", 32'(bus.b), 32'h8);
    check("cnt_stream_ovf", 32'(bus.b_ovf), 1);
    step();
    step();
    step();
    check("cnt_drained", 32'(bus.out_valid), 0);
    check("cnt_saturated", 32'(bus.err_count), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
